dff_rs_sync_async: RTL and testbench

- Dual D flip-flop bank that compares synchronous and asynchronous set/reset styles side by side.
- One shared data input `d` drives two registers:
  - `q_sync` applies `set_n`/`reset_n` only at the rising clock edge.
  - `q_async` applies them immediately.
- Used as a reference storage primitive and for teaching and verification of reset styles. It sits directly on the clock and reset tree.

---
 rtl/dff_rs_sync_async.sv | 67 ++++++
 tb/tb_dff_rs_sync_async.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dff_rs_sync_async.sv
// Dual D flip-flop bank comparing synchronous and asynchronous set/clear styles.
// Both registers share one data input. Priority for both, highest first:
// rst > reset_n low > set_n low > capture d.
//
// Ports:
//   clk      rising-edge clock
//   rst      global reset, asynchronous, active-high; forces both outputs to 0
//   set_n    functional set, active-low (sync for q_sync, async for q_async)
//   reset_n  functional clear, active-low (sync for q_sync, async for q_async)
//   d        data input, WIDTH bits
//   q_sync   register with synchronous set/clear
//   q_async  register with asynchronous set/clear
module dff_rs_sync_async #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_n,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_sync,
    output logic [WIDTH-1:0] q_async
);

    logic [WIDTH-1:0] q_sync_q, q_sync_d;
    logic [WIDTH-1:0] q_async_q;
    logic             async_clr;
    logic             async_set;

    // Synchronous-style register: set/clear only take effect at the clock edge.
    always_comb begin
        q_sync_d = d;
        if (!reset_n) begin
            q_sync_d = '0;
        end else if (!set_n) begin
            q_sync_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_sync_q <= '0;
        end else begin
            q_sync_q <= q_sync_d;
        end
    end

    // Set is masked by clear, so releasing the clear while set is still held
    // produces a rising edge on async_set and the register goes to all ones
    // in the same time step rather than waiting for the clock.
    assign async_clr = rst | ~reset_n;
    assign async_set = ~set_n & ~async_clr;

    always_ff @(posedge clk or posedge async_clr or posedge async_set) begin
        if (async_clr) begin
            q_async_q <= '0;
        end else if (async_set) begin
            q_async_q <= '1;
        end else begin
            q_async_q <= d;
        end
    end

    assign q_sync  = q_sync_q;
    assign q_async = q_async_q;

endmodule

// File: tb/tb_dff_rs_sync_async.sv
`timescale 1ns/1ps
module tb_dff_rs_sync_async;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_n, reset_n;
    logic [0:0] d1;
    logic [0:0] qs1, qa1;
    logic       set_n8, reset_n8;
    logic [7:0] d8;
    logic [7:0] qs8, qa8;
    logic       toggle_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    dff_rs_sync_async #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .set_n   (set_n),
        .reset_n (reset_n),
        .d       (d1),
        .q_sync  (qs1),
        .q_async (qa1)
    );

    dff_rs_sync_async #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .set_n   (set_n8),
        .reset_n (reset_n8),
        .d       (d8),
        .q_sync  (qs8),
        .q_async (qa8)
    );

    // Rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // d toggles every 10 ns while enabled (changes at 10, 20, ...).
    always #10 if (toggle_en) d1 = ~d1;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    initial begin
        rst = 1'b1; set_n = 1'b0; reset_n = 1'b0; d1 = 1'b1; toggle_en = 1'b1;
        set_n8 = 1'b1; reset_n8 = 1'b1; d8 = 8'h00;
        at(1);
        check_eq("rst_qs", {7'b0, qs1}, 8'h00);
        check_eq("rst_qa", {7'b0, qa1}, 8'h00);
        check_eq("rst_qs8", qs8, 8'h00);
        check_eq("rst_qa8", qa8, 8'h00);
        at(2); rst = 1'b0;

        // Both controls low: clear wins.
        at(37);
        check_eq("both_low_qs", {7'b0, qs1}, 8'h00);
        check_eq("both_low_qa", {7'b0, qa1}, 8'h00);

        // Release clear with set still low.
        at(40); reset_n = 1'b1;
        at(41);
        check_eq("rel_clr_qa", {7'b0, qa1}, 8'h01);
        check_eq("rel_clr_qs_pre", {7'b0, qs1}, 8'h00);
        at(46);
        check_eq("rel_clr_qs_edge", {7'b0, qs1}, 8'h01);
        at(76);
        check_eq("set_hold_qs", {7'b0, qs1}, 8'h01);
        check_eq("set_hold_qa", {7'b0, qa1}, 8'h01);

        // Release set: follow d.
        at(80); set_n = 1'b1;
        at(86);   // edge 85 samples d=1
        check_eq("cap85_qs", {7'b0, qs1}, 8'h01);
        check_eq("cap85_qa", {7'b0, qa1}, 8'h01);
        at(96);   // edge 95 samples d=0
        check_eq("cap95_qs", {7'b0, qs1}, 8'h00);
        check_eq("cap95_qa", {7'b0, qa1}, 8'h00);
        at(106);  // edge 105 samples d=1
        check_eq("cap105_qs", {7'b0, qs1}, 8'h01);
        check_eq("cap105_qa", {7'b0, qa1}, 8'h01);

        // Clear falls mid-cycle.
        at(120); reset_n = 1'b0;
        at(121);
        check_eq("clr_mid_qa", {7'b0, qa1}, 8'h00);
        at(126);
        check_eq("clr_edge_qs", {7'b0, qs1}, 8'h00);
        at(136);
        check_eq("clr_hold_qs", {7'b0, qs1}, 8'h00);
        check_eq("clr_hold_qa", {7'b0, qa1}, 8'h00);

        // Global reset pulse mid-cycle with d=1.
        at(140); toggle_en = 1'b0; reset_n = 1'b1; d1 = 1'b1;
        at(147);
        check_eq("pre_rst_qs", {7'b0, qs1}, 8'h01);
        check_eq("pre_rst_qa", {7'b0, qa1}, 8'h01);
        at(148); rst = 1'b1;
        at(149);
        check_eq("rst_mid_qs", {7'b0, qs1}, 8'h00);
        check_eq("rst_mid_qa", {7'b0, qa1}, 8'h00);
        at(151); rst = 1'b0;
        at(152);
        check_eq("post_rst_qs", {7'b0, qs1}, 8'h00);
        check_eq("post_rst_qa", {7'b0, qa1}, 8'h00);
        at(156);
        check_eq("reload_qs", {7'b0, qs1}, 8'h01);
        check_eq("reload_qa", {7'b0, qa1}, 8'h01);

        // Set pulse between edges: async sees it, sync ignores it.
        at(157); d1 = 1'b0;
        at(166);
        check_eq("d0_qs", {7'b0, qs1}, 8'h00);
        at(167); set_n = 1'b0;
        at(168);
        check_eq("set_pulse_qa", {7'b0, qa1}, 8'h01);
        check_eq("set_pulse_qs", {7'b0, qs1}, 8'h00);
        at(169); set_n = 1'b1;
        at(170);
        check_eq("set_rel_hold_qa", {7'b0, qa1}, 8'h01);
        at(176);
        check_eq("after_pulse_qs", {7'b0, qs1}, 8'h00);
        check_eq("after_pulse_qa", {7'b0, qa1}, 8'h00);

        // Both low again, then release both: q_async holds until next edge.
        at(177); set_n = 1'b0; reset_n = 1'b0;
        at(186);
        check_eq("both_low2_qs", {7'b0, qs1}, 8'h00);
        check_eq("both_low2_qa", {7'b0, qa1}, 8'h00);
        at(188); set_n = 1'b1; reset_n = 1'b1; d1 = 1'b1;
        at(189);
        check_eq("rel_both_hold_qa", {7'b0, qa1}, 8'h00);
        at(196);
        check_eq("rel_both_qs", {7'b0, qs1}, 8'h01);
        check_eq("rel_both_qa", {7'b0, qa1}, 8'h01);

        // WIDTH=8 bank.
        at(200); set_n8 = 1'b0;
        at(201);
        check_eq("w8_set_qa", qa8, 8'hFF);
        check_eq("w8_set_qs_pre", qs8, 8'h00);
        at(206);
        check_eq("w8_set_qs", qs8, 8'hFF);
        at(207); set_n8 = 1'b1; d8 = 8'hA5;
        at(211);
        check_eq("w8_hold_qa", qa8, 8'hFF);
        at(216);
        check_eq("w8_cap_qs", qs8, 8'hA5);
        check_eq("w8_cap_qa", qa8, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
